// File: rtl/clock_pkg.sv
// Shared mode encoding, field limits and wrap helpers for the clock controller.
// SET_AL_HR / SET_AL_MIN are only reachable when CLOCK_ALARM_EN is defined.
package clock_pkg;

    localparam int HR_W   = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int MODE_W = 3;

    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    typedef enum logic [MODE_W-1:0] {
        RUN        = 3'd0,
        SET_HR     = 3'd1,
        SET_MIN    = 3'd2,
        SET_AL_HR  = 3'd3,
        SET_AL_MIN = 3'd4
    } mode_t;

    // Wrap to zero at (or beyond) the limit so a field can never escape its range.
    function automatic logic [HR_W-1:0] wrap_inc_hr(input logic [HR_W-1:0] v);
        return (v >= HR_MAX) ? '0 : v + 5'd1;
    endfunction

    function automatic logic [MIN_W-1:0] wrap_inc_60(input logic [MIN_W-1:0] v,
                                                     input logic [MIN_W-1:0] max);
        return (v >= max) ? '0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/clock_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled, pulses tick on the last count.
module clock_tick_gen
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int CNT_W    = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] TC = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = enable && (cnt_q == TC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Run/set mode FSM and hh:mm:ss registers for the digital clock.
// Define CLOCK_ALARM_EN to add the alarm set states, alarm registers and alarm output.
//
// state      | meaning
// RUN        | time advances on each tick; btn_inc ignored
// SET_HR     | time frozen; btn_inc steps hours
// SET_MIN    | time frozen; btn_inc steps minutes (no carry)
// SET_AL_HR  | (alarm build) btn_inc steps alarm hours
// SET_AL_MIN | (alarm build) btn_inc steps alarm minutes
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int CNT_W    = 27
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_mode,
    input  logic              btn_inc,
`ifdef CLOCK_ALARM_EN
    input  logic              alarm_arm,
    output logic              alarm,
`endif
    output logic [HR_W-1:0]   hours,
    output logic [MIN_W-1:0]  mins,
    output logic [SEC_W-1:0]  secs,
    output logic [MODE_W-1:0] mode,
    output logic              tick
);

    mode_t             mode_q, mode_nxt;
    logic [HR_W-1:0]   hours_q, hours_nxt;
    logic [MIN_W-1:0]  mins_q, mins_nxt;
    logic [SEC_W-1:0]  secs_q, secs_nxt;
    logic              tick_en;
    logic              tick_clr;

`ifdef CLOCK_ALARM_EN
    logic [HR_W-1:0]   al_hours_q, al_hours_nxt;
    logic [MIN_W-1:0]  al_mins_q, al_mins_nxt;
    logic              alarm_q, alarm_nxt;
`endif

    // Prescaler only runs in RUN and sits at zero in every set state, so leaving
    // a set state restarts the full one-second period.
    assign tick_en  = (mode_q == RUN);
    assign tick_clr = (mode_q != RUN);

    clock_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (tick_en),
        .clear  (tick_clr),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q  <= RUN;
            hours_q <= '0;
            mins_q  <= '0;
            secs_q  <= '0;
        end else begin
            mode_q  <= mode_nxt;
            hours_q <= hours_nxt;
            mins_q  <= mins_nxt;
            secs_q  <= secs_nxt;
        end
    end

    // A mode press always takes priority; a coincident inc is dropped.
    always_comb begin
        mode_nxt  = mode_q;
        hours_nxt = hours_q;
        mins_nxt  = mins_q;
        secs_nxt  = secs_q;
`ifdef CLOCK_ALARM_EN
        al_hours_nxt = al_hours_q;
        al_mins_nxt  = al_mins_q;
`endif
        case (mode_q)
            RUN: begin
                if (tick) begin
                    if (secs_q >= SEC_MAX) begin
                        secs_nxt = '0;
                        if (mins_q >= MIN_MAX) begin
                            mins_nxt  = '0;
                            hours_nxt = wrap_inc_hr(hours_q);
                        end else begin
                            mins_nxt = mins_q + 6'd1;
                        end
                    end else begin
                        secs_nxt = secs_q + 6'd1;
                    end
                end
                if (btn_mode) begin
                    mode_nxt = SET_HR;
                end
            end
            SET_HR: begin
                if (btn_mode) begin
                    mode_nxt = SET_MIN;
                end else if (btn_inc) begin
                    hours_nxt = wrap_inc_hr(hours_q);
                end
            end
            SET_MIN: begin
                if (btn_mode) begin
`ifdef CLOCK_ALARM_EN
                    mode_nxt = SET_AL_HR;
`else
                    mode_nxt = RUN;
                    secs_nxt = '0;
`endif
                end else if (btn_inc) begin
                    mins_nxt = wrap_inc_60(mins_q, MIN_MAX);
                end
            end
`ifdef CLOCK_ALARM_EN
            SET_AL_HR: begin
                if (btn_mode) begin
                    mode_nxt = SET_AL_MIN;
                end else if (btn_inc) begin
                    al_hours_nxt = wrap_inc_hr(al_hours_q);
                end
            end
            SET_AL_MIN: begin
                if (btn_mode) begin
                    mode_nxt = RUN;
                    secs_nxt = '0;
                end else if (btn_inc) begin
                    al_mins_nxt = wrap_inc_60(al_mins_q, MIN_MAX);
                end
            end
`endif
            default: begin
                mode_nxt = RUN;
            end
        endcase
    end

`ifdef CLOCK_ALARM_EN
    // Set wins over the minute-change clear: the matching edge is itself a minute change.
    always_comb begin
        alarm_nxt = alarm_q;
        if (mode_nxt != RUN) begin
            alarm_nxt = 1'b0;
        end else if (mode_q == RUN && btn_inc) begin
            alarm_nxt = 1'b0;
        end else if (!alarm_arm) begin
            alarm_nxt = 1'b0;
        end else if (mode_q == RUN && tick && secs_nxt == '0 &&
                     hours_nxt == al_hours_q && mins_nxt == al_mins_q) begin
            alarm_nxt = 1'b1;
        end else if (mins_nxt != mins_q) begin
            alarm_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            al_hours_q <= '0;
            al_mins_q  <= '0;
            alarm_q    <= 1'b0;
        end else begin
            al_hours_q <= al_hours_nxt;
            al_mins_q  <= al_mins_nxt;
            alarm_q    <= alarm_nxt;
        end
    end

    assign alarm = alarm_q;
`endif

    assign hours = hours_q;
    assign mins  = mins_q;
    assign secs  = secs_q;
    assign mode  = mode_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with TICK_DIV=4; time is modelled as seconds-of-day.
module tb_clock_mode_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] hours;
    logic [5:0] mins;
    logic [5:0] secs;
    logic [2:0] mode;
    logic       tick;
`ifdef CLOCK_ALARM_EN
    logic       alarm_arm = 1'b0;
    logic       alarm;
`endif

    clock_mode_ctrl #(.TICK_DIV(TD), .CNT_W(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
`ifdef CLOCK_ALARM_EN
        .alarm_arm(alarm_arm),
        .alarm    (alarm),
`endif
        .hours    (hours),
        .mins     (mins),
        .secs     (secs),
        .mode     (mode),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: time as seconds of day, mode as 0..4, prescaler phase, alarm minute of day.
    int m_t = 0;
    int m_mode = 0;
    int m_phase = 0;
    int m_al = 0;
    int m_alarm = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_tick();
        return (m_mode == 0 && m_phase == TD - 1) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_t = 0; m_mode = 0; m_phase = 0; m_al = 0; m_alarm = 0;
    endtask

    task automatic model_step(input bit bm, input bit bi);
        int old_mode = m_mode;
        int old_t = m_t;
        int tk = m_tick();
        int h = m_t / 3600;
        int m = (m_t / 60) % 60;
        int s = m_t % 60;
        int arm = 0;
`ifdef CLOCK_ALARM_EN
        arm = int'(alarm_arm);
`endif
        case (old_mode)
            0: begin
                if (tk == 1) m_t = (m_t + 1) % 86400;
                if (bm) m_mode = 1;
            end
            1: if (bm) m_mode = 2;
               else if (bi) m_t = ((h + 1) % 24) * 3600 + m * 60 + s;
            2: if (bm) begin
`ifdef CLOCK_ALARM_EN
                   m_mode = 3;
`else
                   m_mode = 0;
                   m_t = m_t - s;
`endif
               end else if (bi) m_t = h * 3600 + ((m + 1) % 60) * 60 + s;
            3: if (bm) m_mode = 4;
               else if (bi) m_al = (((m_al / 60) + 1) % 24) * 60 + (m_al % 60);
            4: if (bm) begin
                   m_mode = 0;
                   m_t = m_t - s;
               end else if (bi) m_al = (m_al / 60) * 60 + ((m_al % 60) + 1) % 60;
            default: m_mode = 0;
        endcase
        m_phase = (old_mode == 0) ? (m_phase + 1) % TD : 0;
        if (m_mode != 0) m_alarm = 0;
        else if (old_mode == 0 && bi) m_alarm = 0;
        else if (arm == 0) m_alarm = 0;
        else if (old_mode == 0 && tk == 1 && m_t % 60 == 0 && m_t / 60 == m_al) m_alarm = 1;
        else if (m_t / 60 != old_t / 60) m_alarm = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("hours", int'(hours), m_t / 3600);
            check("mins", int'(mins), (m_t / 60) % 60);
            check("secs", int'(secs), m_t % 60);
            check("mode", int'(mode), m_mode);
            check("tick", int'(tick), m_tick());
`ifdef CLOCK_ALARM_EN
            check("alarm", int'(alarm), m_alarm);
`endif
        end
    end

    task automatic step(input bit bm, input bit bi);
        btn_mode = bm;
        btn_inc  = bi;
        @(posedge clk);
        model_step(bm, bi);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic steps(input int n, input bit bm, input bit bi);
        for (int i = 0; i < n; i++) step(bm, bi);
    endtask

    task automatic exit_set_min();
`ifdef CLOCK_ALARM_EN
        steps(3, 1'b1, 1'b0);
`else
        step(1'b1, 1'b0);
`endif
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b0;
        model_reset();
        #1;
        check("rst_mode", int'(mode), 0);
        check("rst_time", int'(hours) + int'(mins) + int'(secs), 0);
        #1 reset = 1'b1;
    endtask

    initial begin
        int nt;
        model_reset();
        chk_en = 1'b1;
        #1;
        check("por_hours", int'(hours), 0);
        check("por_mode", int'(mode), 0);
        check("por_tick", int'(tick), 0);
        #1 reset = 1'b1;

        nt = 0;
        for (int i = 0; i < 12; i++) begin
            if (tick) nt++;
            step(1'b0, 1'b0);
        end
        check("ticks_in_12", nt, 3);
        check("secs_after_3", int'(secs), 3);
        check("mins_after_3", int'(mins), 0);

        steps(2, 1'b0, 1'b1);
        check("inc_ignored_run", int'(secs), 3);

        step(1'b1, 1'b0);
        steps(25, 1'b0, 1'b1);
        check("set_hr_mode", int'(mode), 1);
        check("hr_wrap_25", int'(hours), 1);
        check("secs_frozen", int'(secs), 3);

        step(1'b1, 1'b0);
        steps(59, 1'b0, 1'b1);
        check("mins_59", int'(mins), 59);
        step(1'b0, 1'b1);
        check("min_wrap", int'(mins), 0);
        check("min_no_carry", int'(hours), 1);

        exit_set_min();
        check("exit_mode", int'(mode), 0);
        check("exit_secs", int'(secs), 0);
        nt = 0;
        for (int i = 0; i < 3; i++) begin
            if (tick) nt++;
            step(1'b0, 1'b0);
        end
        check("no_early_tick", nt, 0);
        check("first_tick", int'(tick), 1);
        step(1'b0, 1'b0);
        check("secs_after_first", int'(secs), 1);

        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("simul_mode", int'(mode), 2);
        check("simul_hours", int'(hours), 1);
        check("simul_mins", int'(mins), 0);

        steps(59, 1'b0, 1'b1);
        exit_set_min();
        step(1'b1, 1'b0);
        steps(22, 1'b0, 1'b1);
        step(1'b1, 1'b0);
        exit_set_min();
        check("preroll_hours", int'(hours), 23);
        check("preroll_mins", int'(mins), 59);
        steps(59 * TD, 1'b0, 1'b0);
        check("preroll_secs", int'(secs), 59);
        steps(TD - 1, 1'b0, 1'b0);
        check("roll_tick", int'(tick), 1);
        step(1'b0, 1'b0);
        check("roll_hours", int'(hours), 0);
        check("roll_mins", int'(mins), 0);
        check("roll_secs", int'(secs), 0);

        steps(2, 1'b1, 1'b0);
        steps(5, 1'b0, 1'b1);
        check("pre_rst_mins", int'(mins), 5);
        pulse_reset();
        steps(6, 1'b0, 1'b0);
        check("post_rst_secs", int'(secs), 1);

`ifdef CLOCK_ALARM_EN
        pulse_reset();
        steps(4, 1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        alarm_arm = 1'b1;
        steps(60 * TD - 1, 1'b0, 1'b0);
        check("alarm_early", int'(alarm), 0);
        step(1'b0, 1'b0);
        check("alarm_set", int'(alarm), 1);
        check("alarm_mins", int'(mins), 1);
        step(1'b0, 1'b1);
        check("alarm_inc_clr", int'(alarm), 0);

        pulse_reset();
        alarm_arm = 1'b0;
        steps(4, 1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        steps(60 * TD, 1'b0, 1'b0);
        check("alarm_disarmed", int'(alarm), 0);
        check("disarmed_mins", int'(mins), 1);
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
- Mode and sequencing controller for the multimodal digital clock.
- Generates the 1 Hz advance from the system clock and runs a run/set state machine driven by user buttons.
- Owns the hours/minutes/seconds registers with legal wrap limits: 0-23 and 0-59.
- Feeds the display path directly; each counter is registered.

Parameters:
- TICK_DIV, 100000000, clk cycles per one-second advance; must be >= 2.
- CNT_W, 27, prescaler width; must satisfy 2**CNT_W >= TICK_DIV.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  reset is asynchronous and active-low.
- btn_mode  input  1  single-cycle pulse, debounced upstream; advances mode.
- btn_inc  input  1  single-cycle pulse, debounced upstream; increments the selected field.
- hours  output  5  current hours, 0-23.
- mins  output  6  current minutes, 0-59.
- secs  output  6  current seconds, 0-59.
- mode  output  3  current state encoding, from the package.
- tick  output  1  one-cycle pulse on each one-second boundary; asserted in RUN only.

Behaviour:
- Reset (async assert, sync-free release): hours=0, mins=0, secs=0, mode=RUN, prescaler=0, tick=0.
- Prescaler:
  - Counts only in RUN: 0..TICK_DIV-1, then wraps to 0.
  - tick is combinational, high while prescaler==TICK_DIV-1 and mode==RUN.
  - The time advance is committed on that same edge.
- States: RUN=0, SET_HR=1, SET_MIN=2.
- Transitions on btn_mode: RUN->SET_HR->SET_MIN->RUN.
- RUN:
  - On tick, secs+1.
  - secs 59->0 carries mins+1; mins 59->0 carries hours+1; hours 23->0.
  - Carry chain completes on a single edge: 23:59:59 -> 00:00:00.
  - btn_inc is ignored.
- SET_HR:
  - Time frozen; prescaler held at 0.
  - btn_inc: hours 23->0, else +1. No effect on mins.
- SET_MIN:
  - Time frozen; prescaler held at 0.
  - btn_inc: mins 59->0, else +1. No carry into hours.
- Exit SET_MIN->RUN: secs cleared to 0 and prescaler cleared on the same edge. The first tick follows exactly TICK_DIV cycles later.
- Latency: a button pulse sampled at edge N updates the outputs after edge N, so it is visible in cycle N+1.
- Simultaneous btn_mode and btn_inc: the mode change wins and inc is dropped. The field is not modified in either the old or the new state.
- Reset asserted mid-set: returns immediately to RUN at 00:00:00; any partial edits are lost.
- Outputs never leave their legal ranges; out-of-range values are unreachable.

Optional Feature:
- Macro: CLOCK_ALARM_EN.
- Defined:
  - States SET_AL_HR=3 and SET_AL_MIN=4 are inserted: SET_MIN->SET_AL_HR->SET_AL_MIN->RUN. The secs clear applies on exit from SET_AL_MIN instead.
  - Alarm registers al_hours and al_mins reset to 0. btn_inc wraps them exactly like the time fields.
  - Added ports:
    - alarm_arm, input, 1 bit.
    - alarm, output, 1 bit, registered, reset 0.
  - alarm is set when mode==RUN, alarm_arm=1, hours==al_hours, mins==al_mins and secs==0 (on the edge where secs becomes 0).
  - alarm is cleared by btn_inc in RUN, by alarm_arm=0, or when the minute changes.
  - alarm is forced to 0 outside RUN.
- Undefined: only 3 states exist; no alarm ports or registers; mode values 3-7 never occur.

Decomposition:
- Package clock_pkg:
  - Mode enum/localparams (RUN, SET_HR, SET_MIN, SET_AL_HR, SET_AL_MIN).
  - HR_MAX=23, MIN_MAX=59, SEC_MAX=59.
  - Field widths 5/6/6.
- Sub-module clock_tick_gen (parameter TICK_DIV):
  - Inputs: clk, reset, enable, clear.
  - Output: tick.
  - Instantiated once.
- FSM and field wrap logic stay in clock_mode_ctrl.

Test Plan (TICK_DIV=4):
- Reset, run 12 cycles -> tick every 4th cycle; secs=3 and mins=0 after the 3rd tick.
- Force the time near rollover (via set mode to 23:59, then 59 ticks) -> the next tick gives 00:00:00 in one cycle.
- btn_mode once, btn_inc x25 -> mode=SET_HR, hours=1 (wrapped at 23->0); secs and prescaler frozen during set.
- SET_MIN with mins=59, btn_inc -> mins=0 and hours unchanged. btn_mode -> RUN with secs=0; first tick exactly 4 cycles later.
- btn_mode and btn_inc in the same cycle while in SET_HR -> mode=SET_MIN, hours unchanged. Reset pulse mid-SET_MIN -> mode=RUN, 00:00:00 immediately.
- CLOCK_ALARM_EN: set alarm 00:01, alarm_arm=1, run 60 ticks -> alarm=1 at 00:01:00; btn_inc clears it. Rerun with alarm_arm=0 -> alarm stays 0.
